exec_sequencer: RTL and testbench
=================================

# exec_sequencer

Multi-cycle execute controller for the 32-bit non-pipelined processor; sits directly upstream of the ALU. It accepts one instruction at a time over a valid/ready handshake and decodes it. It reads operands from an internal 32x32 register file, drives the ALU operands and 3-bit ALU control, then captures the ALU result and zero flag and writes the result back.

## Interface
Parameters:
- NREGS, 32: register count; index width is $clog2(NREGS)=5.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  upstream presents an instruction.
- instr_ready  out  1  sequencer can accept; high only in IDLE.
- instr  in  32  instruction word.
- alu_a  out  32  ALU operand A (rs1 value).
- alu_b  out  32  ALU operand B (rs2 value or sign-extended imm).
- alu_ctrl  out  3  ALU operation select.
- alu_result  in  32  ALU combinational result.
- alu_zero  in  1  ALU zero flag.
- done  out  1  one-cycle pulse: instruction retired.
- result  out  32  last retired result; held until next done.
- zero  out  1  last retired zero flag; held.
- illegal  out  1  valid with done: opcode was unsupported.
- dbg_addr  in  5  debug register index.
- dbg_data  out  32  combinational read of reg[dbg_addr]; reg 0 reads 0.

## Operation
- Instruction fields: opcode [6:0], rd [11:7], op [14:12], rs1 [19:15], rs2 [24:20], imm [31:20] (I-type).
- Opcode 7'b0110011 = R-type: B = reg[rs2]. Opcode 7'b0010011 = I-type: B = {{20{imm[11]}}, imm}. Any other opcode is illegal.
- alu_ctrl = op directly: 000 AND, 001 OR, 010 XOR, 011 ADD, 100 SUB, 101 SLL, 110 SRL, 111 SRA.
- For op 101/110/111, alu_b = {27'b0, B[4:0]}. The shift amount is masked to 5 bits.
- Register 0 always reads 0. Writes to rd=0 are discarded.
- FSM states: IDLE, DECODE, EXEC, WB.
  - IDLE: instr_ready=1. On instr_valid&&instr_ready, latch instr and go to DECODE.
  - DECODE: read rs1/rs2, latch alu_a/alu_b/alu_ctrl. Illegal opcode goes straight to WB with the illegal flag set. Otherwise go to EXEC.
  - EXEC: alu_* are stable. At the clock edge, capture alu_result and alu_zero, then go to WB.
  - WB: write the captured result to rd if legal. Pulse done, update result/zero/illegal, go to IDLE.
- Illegal instruction: no register write. result and zero keep their prior values. illegal=1 for that done pulse.
- alu_a, alu_b and alu_ctrl hold their values outside DECODE/EXEC, changing only in DECODE.

## Timing
- Handshake accepted at edge T0. DECODE runs in cycle T0+1, EXEC in T0+2 and WB in T0+3.
- done is high in cycle T0+3. The register write is visible on dbg_data from T0+4.
- instr_ready rises in cycle T0+4. Throughput is one instruction per 4 cycles; illegal instructions take 3.
- There is no RAW hazard: a write lands before the next DECODE, so no forwarding is needed.
- instr_valid without instr_ready is ignored. The upstream must hold instr until the handshake completes.
- Reset, asynchronous at any state: FSM returns to IDLE and every register-file entry clears to 0. Outputs go to alu_a=0, alu_b=0, alu_ctrl=000, done=0, result=0, zero=0, illegal=0, instr_ready=1 after deassertion. An in-flight instruction is dropped with no write.

## Structure
- Package exec_pkg holds:
  - state enum {IDLE, DECODE, EXEC, WB};
  - opcode constants OP_RTYPE=7'b0110011 and OP_ITYPE=7'b0010011;
  - ALU op localparams ALU_AND … ALU_SRA, matching the encoding above.
- Sub-module reg_file: NREGS x 32, two asynchronous read ports plus the debug read port, one synchronous write port, async active-low clear, reg 0 hardwired to 0.
- The FSM, decode and operand mux live in exec_sequencer. The ALU is instantiated at the top level, not inside this block.

## Test plan
- Reset mid-EXEC, then run I-type ADDI x1,x0,5 (op 011) → done at T0+3, result=5, zero=0, dbg reg1=5; check that no write from the dropped instruction occurred.
- R-type with x1=5, x2=5, SUB rd=3 → alu_ctrl=100, result=0, zero=1, reg3=0; then ADD rd=0 → reg0 still reads 0.
- I-type imm=12'hFFF (-1), ADD to x1=5 → alu_b=32'hFFFFFFFF, result=4.
- SLL with x2=32'h00000021 → alu_b=1, result=x1<<1; the masking check passes.
- Opcode 7'b1111111 → done at T0+2 with illegal=1, no register change, result unchanged.
- Back-to-back instr_valid held high for two instructions: the second is accepted exactly 4 cycles after the first and reads the first's written value.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared types and constants for the execute sequencer.
// Holds the FSM state encoding, supported opcodes and ALU operation codes.
// No ports; imported by exec_sequencer and reg_file.
`timescale 1ns/1ps
package exec_pkg;

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_XOR = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SRA = 3'b111;

  // Shift ops only consume the low five bits of operand B.
  function automatic logic is_shift(input logic [2:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/exec_sequencer_reg_file.sv
// reg_file: NREGS x 32 register file, register 0 hardwired to zero.
// Latency: reads are combinational; a write is visible the cycle after we.
// Backpressure: none, write port always accepts.
// Ports: clk/rst_n (async clear of all entries), ra1/rd1 and ra2/rd2 operand
// read ports, dbg_addr/dbg_data debug read port, we/wa/wd write port.
`timescale 1ns/1ps
module reg_file
  import exec_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ra1,
  output logic [31:0]   rd1,
  input  logic [AW-1:0] ra2,
  output logic [31:0]   rd2,
  input  logic [AW-1:0] dbg_addr,
  output logic [31:0]   dbg_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd
);

  logic [31:0] mem [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Entry 0 is never written, but force the read anyway so x0 is zero by
  // construction rather than by relying on the write guard.
  assign rd1      = (ra1 == '0)      ? '0 : mem[ra1];
  assign rd2      = (ra2 == '0)      ? '0 : mem[ra2];
  assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle execute controller feeding an external ALU.
// Latency: accept -> done in 3 cycles (2 for illegal opcodes); 1 instr per 4.
// Backpressure: instr_ready is high only in IDLE; valid without ready ignored.
// Ports: instr_valid/instr_ready/instr upstream handshake; alu_a/alu_b/
// alu_ctrl out to ALU, alu_result/alu_zero back; done/result/zero/illegal
// retirement status; dbg_addr/dbg_data combinational register peek.
`timescale 1ns/1ps
module exec_sequencer
  import exec_pkg::*;
#(
  parameter int NREGS = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     instr_valid,
  output logic                     instr_ready,
  input  logic [31:0]              instr,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [2:0]               alu_ctrl,
  input  logic [31:0]              alu_result,
  input  logic                     alu_zero,
  output logic                     done,
  output logic [31:0]              result,
  output logic                     zero,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [31:0]              dbg_data
);

  localparam int AW = $clog2(NREGS);

  state_t      state;
  logic [31:0] ir;

  logic [6:0]    opcode;
  logic [AW-1:0] rd, rs1, rs2;
  logic [2:0]    op;
  logic [31:0]   rs1_data, rs2_data, b_raw, b_val;
  logic          legal, reg_we;

  assign opcode = ir[6:0];
  assign rd     = ir[7 +: AW];
  assign op     = ir[14:12];
  assign rs1    = ir[15 +: AW];
  assign rs2    = ir[20 +: AW];

  assign legal = (opcode == OP_RTYPE) || (opcode == OP_ITYPE);
  assign b_raw = (opcode == OP_RTYPE) ? rs2_data : {{20{ir[31]}}, ir[31:20]};
  assign b_val = is_shift(op) ? {27'b0, b_raw[4:0]} : b_raw;

  // result already holds the captured ALU value during WB, so it doubles as
  // the write-back data.
  assign reg_we      = (state == WB) && !illegal;
  assign instr_ready = (state == IDLE);

  reg_file #(.NREGS(NREGS)) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (rs1),
    .rd1      (rs1_data),
    .ra2      (rs2),
    .rd2      (rs2_data),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .we       (reg_we),
    .wa       (rd),
    .wd       (result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ir       <= '0;
      alu_a    <= '0;
      alu_b    <= '0;
      alu_ctrl <= '0;
      done     <= 1'b0;
      result   <= '0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (instr_valid) begin
            ir    <= instr;
            state <= DECODE;
          end
        end
        DECODE: begin
          alu_a    <= rs1_data;
          alu_b    <= b_val;
          alu_ctrl <= op;
          if (legal) begin
            state <= EXEC;
          end else begin
            // Skip EXEC: result/zero keep their previous values.
            illegal <= 1'b1;
            done    <= 1'b1;
            state   <= WB;
          end
        end
        EXEC: begin
          result  <= alu_result;
          zero    <= alu_zero;
          illegal <= 1'b0;
          done    <= 1'b1;
          state   <= WB;
        end
        WB: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_sequencer.sv
// tb_exec_sequencer: directed test of exec_sequencer with a behavioural ALU.
// Latency: checks done timing, write-back visibility and handshake spacing.
// Backpressure: drives instr_valid held high across a busy sequencer.
`timescale 1ns/1ps
module tb_exec_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        done;
  logic [31:0] result;
  logic        zero;
  logic        illegal;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;

  int nchk = 0;
  int nerr = 0;
  int lat;
  int acc;

  always #5 clk = ~clk;

  exec_sequencer #(.NREGS(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_ctrl    (alu_ctrl),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .done        (done),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  // External ALU the sequencer drives.
  always_comb begin
    alu_result = '0;
    case (alu_ctrl)
      3'b000: alu_result = alu_a & alu_b;
      3'b001: alu_result = alu_a | alu_b;
      3'b010: alu_result = alu_a ^ alu_b;
      3'b011: alu_result = alu_a + alu_b;
      3'b100: alu_result = alu_a - alu_b;
      3'b101: alu_result = alu_a << alu_b[4:0];
      3'b110: alu_result = alu_a >> alu_b[4:0];
      3'b111: alu_result = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      default: alu_result = '0;
    endcase
  end
  assign alu_zero = (alu_result == 32'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] op, input logic [4:0] rd);
    return {imm, rs1, op, rd, 7'b0010011};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] op, input logic [4:0] rd);
    return {7'b0, rs2, rs1, op, rd, 7'b0110011};
  endfunction

  // Issue one instruction; returns cycles from acceptance edge to done
  // (0 if done never arrives). Returns at the negedge of the done cycle.
  task automatic run(input logic [31:0] iw, output int l);
    @(negedge clk);
    instr       = iw;
    instr_valid = 1'b1;
    chk("ready_before_issue", {31'b0, instr_ready}, 32'd1);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    l = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin
        l = c;
        break;
      end
    end
  endtask

  // Cycle after done: pulse gone, ready back, register write visible.
  task automatic after_wb(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    @(negedge clk);
    dbg_addr = addr;
    #1;
    chk({tag, "_done_low"}, {31'b0, done}, 32'd0);
    chk({tag, "_ready"}, {31'b0, instr_ready}, 32'd1);
    chk({tag, "_reg"}, dbg_data, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    dbg_addr    = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_ready", {31'b0, instr_ready}, 32'd1);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_illegal", {31'b0, illegal}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_ctrl", {29'b0, alu_ctrl}, 32'd0);

    // ADDI x5,x0,7 interrupted by reset during EXEC
    instr       = enc_i(12'd7, 5'd0, 3'b011, 5'd5);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);            // DECODE
    @(negedge clk);            // EXEC
    chk("midexec_alu_b", alu_b, 32'd7);
    rst_n = 1'b0;
    #1;
    chk("midexec_rst_alu_b", alu_b, 32'd0);
    chk("midexec_rst_ready", {31'b0, instr_ready}, 32'd1);
    @(negedge clk);
    rst_n    = 1'b1;
    dbg_addr = 5'd5;
    repeat (4) @(negedge clk);
    chk("dropped_no_write_x5", dbg_data, 32'd0);
    chk("dropped_no_done", {31'b0, done}, 32'd0);

    // ADDI x1,x0,5
    run(enc_i(12'd5, 5'd0, 3'b011, 5'd1), lat);
    chk("addi_latency", 32'(lat), 32'd3);
    chk("addi_result", result, 32'd5);
    chk("addi_zero", {31'b0, zero}, 32'd0);
    chk("addi_illegal", {31'b0, illegal}, 32'd0);
    chk("addi_ready_low", {31'b0, instr_ready}, 32'd0);
    after_wb("addi", 5'd1, 32'd5);

    // ADDI x2,x0,5 ; SUB x3,x1,x2
    run(enc_i(12'd5, 5'd0, 3'b011, 5'd2), lat);
    after_wb("addi_x2", 5'd2, 32'd5);
    run(enc_r(5'd2, 5'd1, 3'b100, 5'd3), lat);
    chk("sub_latency", 32'(lat), 32'd3);
    chk("sub_alu_ctrl", {29'b0, alu_ctrl}, 32'd4);
    chk("sub_result", result, 32'd0);
    chk("sub_zero", {31'b0, zero}, 32'd1);
    after_wb("sub", 5'd3, 32'd0);

    // ADD x0,x1,x2: computed but discarded
    run(enc_r(5'd2, 5'd1, 3'b011, 5'd0), lat);
    chk("add_x0_result", result, 32'd10);
    after_wb("add_x0", 5'd0, 32'd0);

    // ADDI x4,x1,-1
    run(enc_i(12'hFFF, 5'd1, 3'b011, 5'd4), lat);
    chk("addi_neg_alu_b", alu_b, 32'hFFFF_FFFF);
    chk("addi_neg_result", result, 32'd4);
    after_wb("addi_neg", 5'd4, 32'd4);

    // x2 = 0x21 ; SLL x6,x1,x2 uses only shamt 1
    run(enc_i(12'h021, 5'd0, 3'b011, 5'd2), lat);
    after_wb("addi_x2_21", 5'd2, 32'h21);
    run(enc_r(5'd2, 5'd1, 3'b101, 5'd6), lat);
    chk("sll_alu_ctrl", {29'b0, alu_ctrl}, 32'd5);
    chk("sll_alu_b", alu_b, 32'd1);
    chk("sll_result", result, 32'd10);
    after_wb("sll", 5'd6, 32'd10);

    // Illegal opcode 1111111 with rd=1
    run(32'h0000_00FF, lat);
    chk("ill_latency", 32'(lat), 32'd2);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_result_held", result, 32'd10);
    chk("ill_zero_held", {31'b0, zero}, 32'd0);
    after_wb("ill", 5'd1, 32'd5);

    // Back-to-back: ADDI x7,x0,9 then ADD x8,x7,x7 with valid held high
    @(negedge clk);
    dbg_addr    = 5'd7;
    instr       = enc_i(12'd9, 5'd0, 3'b011, 5'd7);
    instr_valid = 1'b1;
    @(posedge clk);
    #1 instr = enc_r(5'd7, 5'd7, 3'b011, 5'd8);
    acc = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (instr_ready) begin
        acc = c;
        break;
      end
    end
    chk("b2b_accept_spacing", 32'(acc), 32'd4);
    chk("b2b_first_written", dbg_data, 32'd9);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    lat = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) begin
        lat = c;
        break;
      end
    end
    chk("b2b_latency", 32'(lat), 32'd3);
    chk("b2b_result", result, 32'd18);
    chk("b2b_illegal_clear", {31'b0, illegal}, 32'd0);
    after_wb("b2b", 5'd8, 32'd18);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
